ahb_sram_sub: RTL and testbench

//  AHB-Lite subordinate that sits directly downstream of the EBU bus manager. It consumes

---
 rtl/ahb_sram_sub.sv | 152 +++++++++++++++
 tb/tb_ahb_sram_sub.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_sub.sv
// AHB-Lite SRAM subordinate: word-organised RAM with programmable data-phase wait states
// and a two-cycle ERROR response for out-of-range, oversized or misaligned transfers.
module ahb_sram_sub #(
    parameter int              AW    = 32,
    parameter int              DW    = 64,
    parameter int              WORDS = 512,
    parameter logic [AW-1:0]   BASE  = '0,
    parameter int              WAIT  = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [AW-1:0]     HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [DW-1:0]     HWDATA,
    input  logic [DW/8-1:0]   HWSTRB,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [DW-1:0]     HRDATA
);
    localparam int NB = DW / 8;
    localparam int OB = $clog2(NB);
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [AW:0] REGION = (AW+1)'(WORDS * NB);
    localparam logic [3:0] WAIT_LOAD = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_DONE, ST_ERR1, ST_ERR2} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [IW-1:0]   idx_q;
    logic            wr_q;
    logic [NB-1:0]   lane_q;
    logic [DW-1:0]   mem [WORDS];

    logic [AW-1:0]   rel;
    logic [IW-1:0]   addr_idx;
    logic [IW-1:0]   rd_idx;
    logic [NB-1:0]   lane_win;
    logic [NB-1:0]   wr_lanes;
    logic [DW-1:0]   wr_merged;
    logic [DW-1:0]   rd_word;
    logic            misaligned;
    logic            addr_err;
    logic            accept;
    logic            commit;
    logic            unused_ok;

    assign unused_ok = HTRANS[0];
    assign rel       = HADDR - BASE;
    assign addr_idx  = rel[OB +: IW];
    assign accept    = HSEL && HTRANS[1] && HREADY &&
                       (state == ST_IDLE || state == ST_DONE || state == ST_ERR2);
    assign commit    = (state == ST_DONE) && wr_q;
    assign wr_lanes  = lane_q & HWSTRB;
    assign rd_idx    = (state == ST_WAIT) ? idx_q : addr_idx;

    always_comb begin
        misaligned = 1'b0;
        for (int b = 0; b < OB; b++)
            if (b < int'(HSIZE))
                misaligned = misaligned | HADDR[b];
        addr_err = ({1'b0, HADDR} < {1'b0, BASE}) || ({1'b0, rel} >= REGION) ||
                   (int'(HSIZE) > OB) || misaligned;
    end

    // Byte lanes covered by HSIZE at this offset; strobes outside the window are dropped.
    always_comb begin
        lane_win = '0;
        for (int l = 0; l < NB; l++)
            if (l >= int'(rel[OB-1:0]) && l < int'(rel[OB-1:0]) + (1 << HSIZE))
                lane_win[l] = 1'b1;
    end

    // A read entering DONE while a write to the same word commits sees the merged word.
    always_comb begin
        wr_merged = mem[idx_q];
        for (int l = 0; l < NB; l++)
            if (wr_lanes[l])
                wr_merged[l*8 +: 8] = HWDATA[l*8 +: 8];
        rd_word = (commit && rd_idx == idx_q) ? wr_merged : mem[rd_idx];
    end

    always_ff @(posedge HCLK) begin
        if (commit)
            for (int l = 0; l < NB; l++)
                if (wr_lanes[l])
                    mem[idx_q][l*8 +: 8] <= HWDATA[l*8 +: 8];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            cnt       <= '0;
            idx_q     <= '0;
            wr_q      <= 1'b0;
            lane_q    <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= ST_DONE;
                        HREADYOUT <= 1'b1;
                        if (!wr_q)
                            HRDATA <= rd_word;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        idx_q  <= addr_idx;
                        wr_q   <= HWRITE;
                        lane_q <= lane_win;
                        if (addr_err) begin
                            state     <= ST_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b1;
                            HRDATA    <= '0;
                        end else if (WAIT > 0) begin
                            state     <= ST_WAIT;
                            cnt       <= WAIT_LOAD;
                            HREADYOUT <= 1'b0;
                            HRESP     <= 1'b0;
                        end else begin
                            state     <= ST_DONE;
                            HREADYOUT <= 1'b1;
                            HRESP     <= 1'b0;
                            if (!HWRITE)
                                HRDATA <= rd_word;
                        end
                    end else begin
                        state     <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ahb_sram_sub.sv
// Bench for ahb_sram_sub: two instances (WAIT=2 and WAIT=0) driven from per-cycle stimulus
// tables, with a transaction-level model filling per-cycle expected outputs.
module tb_ahb_sram_sub;
    localparam int NCYC = 90;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int WORDS_BYTES = 512 * 8;
    localparam int WAIT0 = 2;
    localparam int WAIT1 = 0;

    logic clk;
    logic        rstn   [2];
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [63:0] hwdata [2];
    logic [7:0]  hwstrb [2];
    logic        hready [2];
    logic        hreadyout [2];
    logic        hresp  [2];
    logic [63:0] hrdata [2];

    logic        s_rstn  [2][NCYC];
    logic        s_sel   [2][NCYC];
    logic [1:0]  s_trans [2][NCYC];
    logic        s_write [2][NCYC];
    logic [31:0] s_addr  [2][NCYC];
    logic [2:0]  s_size  [2][NCYC];
    logic [63:0] s_wdata [2][NCYC];
    logic [7:0]  s_strb  [2][NCYC];
    logic        s_hready[2][NCYC];

    logic        exp_rdy  [2][NCYC];
    logic        exp_resp [2][NCYC];
    logic        exp_chk  [2][NCYC];
    logic [63:0] exp_data [2][NCYC];
    logic        act_rdy  [2][NCYC];
    logic [63:0] act_data [2][NCYC];

    logic [63:0] model_mem [2][512];
    int cur [2];
    int n_checks;
    int n_fails;
    int cyc;
    logic running;

    ahb_sram_sub #(.BASE(BASE), .WAIT(WAIT0)) dut0 (
        .HCLK(clk), .HRESETn(rstn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HWDATA(hwdata[0]), .HWSTRB(hwstrb[0]),
        .HREADY(hready[0]), .HREADYOUT(hreadyout[0]), .HRESP(hresp[0]), .HRDATA(hrdata[0]));

    ahb_sram_sub #(.BASE(BASE), .WAIT(WAIT1)) dut1 (
        .HCLK(clk), .HRESETn(rstn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HWDATA(hwdata[1]), .HWSTRB(hwstrb[1]),
        .HREADY(hready[1]), .HREADYOUT(hreadyout[1]), .HRESP(hresp[1]), .HRDATA(hrdata[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transfer at the cursor: address phase, data-phase write data, expected outputs.
    task automatic planXfer(input int i, input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [63:0] wdata,
                            input logic [7:0] strb, output int done_cyc);
        int a, w, idx, off, nbytes;
        logic err;
        a = cur[i];
        w = (i == 0) ? WAIT0 : WAIT1;
        s_sel[i][a] = 1'b1; s_trans[i][a] = 2'b10; s_write[i][a] = wr;
        s_addr[i][a] = addr; s_size[i][a] = size;
        nbytes = 1 << size;
        err = (addr < BASE) || (addr >= BASE + 32'(WORDS_BYTES)) || (size > 3'd3) ||
              ((int'(addr[6:0]) % nbytes) != 0);
        if (err) begin
            for (int k = 1; k <= 2; k++) begin
                exp_rdy[i][a+k] = (k == 2); exp_resp[i][a+k] = 1'b1;
                exp_chk[i][a+k] = 1'b1; exp_data[i][a+k] = 64'd0;
                if (wr) begin s_wdata[i][a+k] = wdata; s_strb[i][a+k] = strb; end
            end
            done_cyc = a + 2;
        end else begin
            idx = int'((addr - BASE) >> 3);
            off = int'(addr[2:0]);
            for (int k = 1; k <= w; k++) exp_rdy[i][a+k] = 1'b0;
            done_cyc = a + 1 + w;
            if (wr) begin
                for (int k = 1; k <= w + 1; k++) begin
                    s_wdata[i][a+k] = wdata; s_strb[i][a+k] = strb;
                end
                for (int b = 0; b < 8; b++)
                    if (strb[b] && b >= off && b < off + nbytes)
                        model_mem[i][idx][b*8 +: 8] = wdata[b*8 +: 8];
            end else begin
                exp_chk[i][done_cyc] = 1'b1;
                exp_data[i][done_cyc] = model_mem[i][idx];
            end
        end
        cur[i] = done_cyc;
    endtask

    // Full-word write (WAIT=2 instance) cut by reset in its second wait cycle; nothing commits.
    task automatic planResetWrite(input int i, input logic [31:0] addr,
                                  input logic [63:0] wdata, output int rst_cyc);
        int a;
        a = cur[i];
        s_sel[i][a] = 1'b1; s_trans[i][a] = 2'b10; s_write[i][a] = 1'b1;
        s_addr[i][a] = addr; s_size[i][a] = 3'd3;
        for (int k = 1; k <= 3; k++) begin s_wdata[i][a+k] = wdata; s_strb[i][a+k] = 8'hFF; end
        exp_rdy[i][a+1] = 1'b0;
        rst_cyc = a + 2;
        s_rstn[i][a+2] = 1'b0;
        exp_chk[i][a+2] = 1'b1; exp_data[i][a+2] = 64'd0;
        exp_chk[i][a+3] = 1'b1; exp_data[i][a+3] = 64'd0;
        cur[i] = a + 4;
    endtask

    // BUSY, unselected NONSEQ, and NONSEQ with HREADY low: none may start a transfer.
    task automatic planNoAccept(input int i, input logic [31:0] addr);
        int a;
        a = cur[i];
        for (int k = 0; k < 3; k++) begin
            s_sel[i][a+2*k] = (k != 1);
            s_trans[i][a+2*k] = (k == 0) ? 2'b01 : 2'b10;
            s_write[i][a+2*k] = 1'b1; s_addr[i][a+2*k] = addr; s_size[i][a+2*k] = 3'd3;
            s_hready[i][a+2*k] = (k != 2);
            s_wdata[i][a+2*k+1] = 64'hFFFF_FFFF_FFFF_FFFF; s_strb[i][a+2*k+1] = 8'hFF;
        end
        cur[i] = a + 6;
    endtask

    task automatic applyStimulus(input int i, input int c);
        rstn[i] = s_rstn[i][c]; hsel[i] = s_sel[i][c]; htrans[i] = s_trans[i][c];
        hwrite[i] = s_write[i][c]; haddr[i] = s_addr[i][c]; hsize[i] = s_size[i][c];
        hwdata[i] = s_wdata[i][c]; hwstrb[i] = s_strb[i][c]; hready[i] = s_hready[i][c];
    endtask

    task automatic checkOutput(input int i, input int c);
        act_rdy[i][c] = hreadyout[i];
        act_data[i][c] = hrdata[i];
        n_checks++;
        if (hreadyout[i] !== exp_rdy[i][c]) begin
            n_fails++;
            $display("[TB] FAIL hreadyout inst%0d cyc%0d: got %b want %b", i, c, hreadyout[i], exp_rdy[i][c]);
        end
        n_checks++;
        if (hresp[i] !== exp_resp[i][c]) begin
            n_fails++;
            $display("[TB] FAIL hresp inst%0d cyc%0d: got %b want %b", i, c, hresp[i], exp_resp[i][c]);
        end
        if (exp_chk[i][c]) begin
            n_checks++;
            if (hrdata[i] !== exp_data[i][c]) begin
                n_fails++;
                $display("[TB] FAIL hrdata inst%0d cyc%0d: got %h want %h", i, c, hrdata[i], exp_data[i][c]);
            end
        end
    endtask

    task automatic pinData(input string name, input int i, input int c, input logic [63:0] want);
        n_checks++;
        if (act_data[i][c] !== want || act_rdy[i][c] !== 1'b1) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h ready %b want %h ready 1", name, act_data[i][c], act_rdy[i][c], want);
        end
    endtask

    always @(negedge clk) begin
        if (running) begin
            checkOutput(0, cyc);
            checkOutput(1, cyc);
        end
    end

    initial begin
        int d, a1, d_s1, d_s3, d_s4, d_s5, d_s6, d_s6b, r6;
        int d_s2, d_s2m, d_s2e, d_b30, d_b38, lows;
        n_checks = 0; n_fails = 0; cyc = 0; running = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < NCYC; c++) begin
                s_rstn[i][c] = 1'b1; s_sel[i][c] = 1'b0; s_trans[i][c] = 2'b00;
                s_write[i][c] = 1'b0; s_addr[i][c] = 32'd0; s_size[i][c] = 3'd0;
                s_wdata[i][c] = 64'd0; s_strb[i][c] = 8'd0; s_hready[i][c] = 1'b1;
                exp_rdy[i][c] = 1'b1; exp_resp[i][c] = 1'b0; exp_chk[i][c] = 1'b0;
                exp_data[i][c] = 64'd0;
            end
            for (int c = 0; c < 2; c++) begin
                s_rstn[i][c] = 1'b0; exp_chk[i][c] = 1'b1;
            end
            cur[i] = 3;
        end

        // WAIT=2 instance: write/read, out-of-range, misaligned, no-accept, reset mid-write.
        a1 = cur[0];
        planXfer(0, 1'b1, BASE + 32'h10, 3'd3, 64'h1122_3344_5566_7788, 8'hFF, d);
        planXfer(0, 1'b0, BASE + 32'h10, 3'd3, 64'd0, 8'h00, d_s1);
        cur[0] += 2;
        planXfer(0, 1'b0, BASE + 32'(WORDS_BYTES), 3'd3, 64'd0, 8'h00, d);
        planXfer(0, 1'b0, BASE + 32'h10, 3'd3, 64'd0, 8'h00, d_s3);
        cur[0] += 2;
        planXfer(0, 1'b1, BASE, 3'd3, 64'h0123_4567_89AB_CDEF, 8'hFF, d);
        planXfer(0, 1'b1, BASE + 32'h2, 3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, d);
        planXfer(0, 1'b0, BASE, 3'd3, 64'd0, 8'h00, d_s4);
        cur[0] += 2;
        planXfer(0, 1'b1, BASE + 32'h40, 3'd3, 64'hCAFE_F00D_DEAD_BEEF, 8'hFF, d);
        cur[0] += 1;
        planNoAccept(0, BASE + 32'h40);
        planXfer(0, 1'b0, BASE + 32'h40, 3'd3, 64'd0, 8'h00, d_s5);
        cur[0] += 2;
        planXfer(0, 1'b1, BASE + 32'h80, 3'd3, 64'h5555_AAAA_5555_AAAA, 8'hFF, d);
        cur[0] += 2;
        planResetWrite(0, BASE + 32'h80, 64'h0, r6);
        planXfer(0, 1'b0, BASE + 32'h80, 3'd3, 64'd0, 8'h00, d_s6);
        planXfer(0, 1'b1, BASE + 32'h88, 3'd3, 64'h0F0F_0F0F_1234_5678, 8'hFF, d);
        planXfer(0, 1'b0, BASE + 32'h88, 3'd3, 64'd0, 8'h00, d_s6b);

        // WAIT=0 instance: forwarding, strobe window masking, error, back-to-back streams.
        planXfer(1, 1'b1, BASE + 32'h20, 3'd3, 64'h0706_0504_0302_0100, 8'hFF, d);
        cur[1] += 1;
        planXfer(1, 1'b1, BASE + 32'h21, 3'd0, 64'h0000_0000_0000_AA00, 8'h02, d);
        planXfer(1, 1'b0, BASE + 32'h20, 3'd3, 64'd0, 8'h00, d_s2);
        cur[1] += 2;
        planXfer(1, 1'b1, BASE + 32'h21, 3'd0, 64'hBBBB_BBBB_BBBB_BBBB, 8'hFF, d);
        planXfer(1, 1'b0, BASE + 32'h20, 3'd3, 64'd0, 8'h00, d_s2m);
        cur[1] += 2;
        planXfer(1, 1'b0, BASE + 32'h23, 3'd1, 64'd0, 8'h00, d);
        planXfer(1, 1'b0, BASE + 32'h20, 3'd3, 64'd0, 8'h00, d_s2e);
        planXfer(1, 1'b1, BASE + 32'h30, 3'd3, 64'h3030_3030_3030_3030, 8'hFF, d);
        planXfer(1, 1'b1, BASE + 32'h38, 3'd3, 64'h3838_3838_3838_3838, 8'hFF, d);
        planXfer(1, 1'b0, BASE + 32'h30, 3'd3, 64'd0, 8'h00, d_b30);
        planXfer(1, 1'b0, BASE + 32'h38, 3'd3, 64'd0, 8'h00, d_b38);

        applyStimulus(0, 0);
        applyStimulus(1, 0);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            applyStimulus(0, c);
            applyStimulus(1, c);
            cyc = c;
            running = 1'b1;
        end
        @(posedge clk);
        #1;
        running = 1'b0;

        pinData("s1_readback", 0, d_s1, 64'h1122_3344_5566_7788);
        lows = 0;
        for (int c = a1 + 1; c <= d_s1; c++)
            if (act_rdy[0][c] == 1'b0) lows++;
        n_checks++;
        if (lows != 4) begin
            n_fails++;
            $display("[TB] FAIL s1_wait_cycles: got %0d want 4", lows);
        end
        pinData("s3_read_after_error", 0, d_s3, 64'h1122_3344_5566_7788);
        pinData("s4_word_unchanged", 0, d_s4, 64'h0123_4567_89AB_CDEF);
        pinData("s5_word_untouched", 0, d_s5, 64'hCAFE_F00D_DEAD_BEEF);
        pinData("s6_async_reset_outputs", 0, r6, 64'd0);
        pinData("s6_write_dropped", 0, d_s6, 64'h5555_AAAA_5555_AAAA);
        pinData("s6_next_transfer", 0, d_s6b, 64'h0F0F_0F0F_1234_5678);
        pinData("s2_forwarded_byte", 1, d_s2, 64'h0706_0504_0302_AA00);
        pinData("s2_strobe_window", 1, d_s2m, 64'h0706_0504_0302_BB00);
        pinData("s2_read_after_error", 1, d_s2e, 64'h0706_0504_0302_BB00);
        pinData("b2b_word30", 1, d_b30, 64'h3030_3030_3030_3030);
        pinData("b2b_word38", 1, d_b38, 64'h3838_3838_3838_3838);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
